data_mem_unit: RTL and testbench

//  Data-memory subsystem directly downstream of the core's MEM stage. Consumes RAM_Addr_o,
//  RAM_DATA_o, RAM_DATA_control and RAM_rw, and returns MEM_result_i in the same cycle.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/data_mem_unit_if.sv | 24 ++
 rtl/tx_fifo.sv | 54 +++++
 rtl/data_mem_unit.sv | 146 ++++++++++++++
 tb/tb_data_mem_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory unit: access-type encoding, peripheral
// address map and STATUS register bit positions.
package dmem_pkg;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_access_t;

   localparam logic [31:0] TXDATA_ADDR   = 32'h8000_0000;
   localparam logic [31:0] STATUS_ADDR   = 32'h8000_0004;
   localparam logic [31:0] CYCLE_LO_ADDR = 32'h8000_0008;
   localparam logic [31:0] CYCLE_HI_ADDR = 32'h8000_000C;
   localparam logic [31:0] CLEAR_ADDR    = 32'h8000_0010;

   localparam int unsigned ST_EMPTY     = 0;
   localparam int unsigned ST_FULL      = 1;
   localparam int unsigned ST_OVERFLOW  = 2;
   localparam int unsigned ST_MISALIGN  = 3;
   localparam int unsigned ST_COUNT_LSB = 8;

endpackage

// File: rtl/data_mem_unit_if.sv
// Core-side memory bus plus TX egress handshake for the data-memory unit.
interface data_mem_unit_if #(
   parameter int unsigned size = 32
);
   logic [size-1:0] addr_i;
   logic [size-1:0] wdata_i;
   logic [2:0]      funct3_i;
   logic            we_i;
   logic [size-1:0] rdata_o;
   logic [7:0]      tx_data_o;
   logic            tx_valid_o;
   logic            tx_ready_i;
   logic            misalign_o;

   modport master (
      output addr_i, wdata_i, funct3_i, we_i, tx_ready_i,
      input  rdata_o, tx_data_o, tx_valid_o, misalign_o
   );

   modport slave (
      input  addr_i, wdata_i, funct3_i, we_i, tx_ready_i,
      output rdata_o, tx_data_o, tx_valid_o, misalign_o
   );
endinterface

// File: rtl/tx_fifo.sv
// Byte FIFO for the transmit peripheral; a push into a full FIFO is still
// accepted when the head is popped in the same cycle.
module tx_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [7:0]                 din,
   input  logic                       pop,
   output logic [7:0]                 dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          accept;
   logic          do_pop;

   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);
   assign count  = count_q;
   assign do_pop = pop & ~empty;
   assign accept = push & (~full | do_pop);
   assign dout   = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         case ({accept, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset; empty masks stale contents on dout.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/data_mem_unit.sv
// Data RAM with byte/half/word access and extension, plus memory-mapped TX FIFO,
// 64-bit cycle counter and sticky error flags.
module data_mem_unit
   import dmem_pkg::*;
#(
   parameter int unsigned size      = 32,
   parameter int unsigned MEM_DEPTH = 1024,
   parameter int unsigned TX_DEPTH  = 8,
   parameter string       INIT_FILE = ""
) (
   input logic            clk,
   input logic            reset,
   data_mem_unit_if.slave bus
);
   localparam int unsigned AW = $clog2(MEM_DEPTH);
   localparam int unsigned CW = $clog2(TX_DEPTH) + 1;
   localparam logic [size-1:0] RAM_LIMIT = size'(MEM_DEPTH * 4);

   logic [size-1:0] ram [MEM_DEPTH];

   logic            f3_valid, is_h, is_w, sext, mis;
   logic            in_ram, store, ram_we, push, pop, clear_wr;
   logic [size-1:0] aligned, rd_word, wd, status;
   logic [AW-1:0]   ram_idx;
   logic [3:0]      be;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [63:0]     cycle_q;
   logic            misalign_q, overflow_q;
   logic [CW-1:0]   tx_count;
   logic            tx_full, tx_empty, tx_valid;

   assign aligned = {bus.addr_i[size-1:2], 2'b00};
   assign in_ram  = (bus.addr_i < RAM_LIMIT);
   assign ram_idx = bus.addr_i[AW+1:2];

   // Access-type decode.
   always_comb begin
      f3_valid = 1'b0;
      is_h     = 1'b0;
      is_w     = 1'b0;
      sext     = 1'b0;
      case (bus.funct3_i)
         MEM_B:   begin f3_valid = 1'b1; sext = 1'b1; end
         MEM_BU:  f3_valid = 1'b1;
         MEM_H:   begin f3_valid = 1'b1; is_h = 1'b1; sext = 1'b1; end
         MEM_HU:  begin f3_valid = 1'b1; is_h = 1'b1; end
         MEM_W:   begin f3_valid = 1'b1; is_w = 1'b1; end
         default: ;
      endcase
   end

   assign mis      = (is_h & bus.addr_i[0]) | (is_w & (|bus.addr_i[1:0]));
   assign store    = bus.we_i & f3_valid & ~mis;
   assign ram_we   = store & in_ram;
   assign push     = store & ~in_ram & (aligned == size'(TXDATA_ADDR));
   assign clear_wr = store & ~in_ram & (aligned == size'(CLEAR_ADDR));
   assign tx_valid = ~tx_empty;
   assign pop      = tx_valid & bus.tx_ready_i;

   always_comb begin
      status                           = '0;
      status[ST_EMPTY]                 = tx_empty;
      status[ST_FULL]                  = tx_full;
      status[ST_OVERFLOW]              = overflow_q;
      status[ST_MISALIGN]              = misalign_q;
      status[ST_COUNT_LSB +: 8]        = 8'(tx_count);
   end

   // Aligned-word read mux: side-effect free, evaluated every cycle.
   always_comb begin
      rd_word = '0;
      if (in_ram)                                rd_word = ram[ram_idx];
      else if (aligned == size'(STATUS_ADDR))    rd_word = status;
      else if (aligned == size'(CYCLE_LO_ADDR))  rd_word = cycle_q[31:0];
      else if (aligned == size'(CYCLE_HI_ADDR))  rd_word = cycle_q[63:32];
   end

   always_comb begin
      case (bus.addr_i[1:0])
         2'd0:    byte_sel = rd_word[7:0];
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = bus.addr_i[1] ? rd_word[31:16] : rd_word[15:0];

      if (!f3_valid || mis)  bus.rdata_o = '0;
      else if (is_w)         bus.rdata_o = rd_word;
      else if (is_h)         bus.rdata_o = {{(size-16){sext & half_sel[15]}}, half_sel};
      else                   bus.rdata_o = {{(size-8){sext & byte_sel[7]}}, byte_sel};
   end

   // Lane enables and replicated store data.
   always_comb begin
      if (is_w) begin
         be = 4'hF;
         wd = bus.wdata_i;
      end else if (is_h) begin
         be = bus.addr_i[1] ? 4'hC : 4'h3;
         wd = {2{bus.wdata_i[15:0]}};
      end else begin
         be = 4'(4'b0001 << bus.addr_i[1:0]);
         wd = {4{bus.wdata_i[7:0]}};
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) ram[ram_idx][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   // Sticky flags: a set event in the same cycle as CLEAR wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         misalign_q <= 1'b0;
         overflow_q <= 1'b0;
         cycle_q    <= '0;
      end else begin
         cycle_q <= cycle_q + 64'd1;
         if (f3_valid && mis)                   misalign_q <= 1'b1;
         else if (clear_wr && bus.wdata_i[0])   misalign_q <= 1'b0;
         if (push && tx_full && !pop)           overflow_q <= 1'b1;
         else if (clear_wr && bus.wdata_i[1])   overflow_q <= 1'b0;
      end
   end

   tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (bus.wdata_i[7:0]),
      .pop   (pop),
      .dout  (bus.tx_data_o),
      .count (tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   assign bus.tx_valid_o = tx_valid;
   assign bus.misalign_o = misalign_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: expected values are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_data_mem_unit;
   import dmem_pkg::*;

   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;
   localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101, F_NONE = 3'b011;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] exp_q [$];
   logic [63:0] tb_cyc;

   data_mem_unit_if #(.size(32)) bus ();

   data_mem_unit u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference cycle count, reset and advanced exactly like the architectural counter.
   always @(posedge clk or posedge reset) begin
      if (reset) tb_cyc <= '0;
      else       tb_cyc <= tb_cyc + 64'd1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic op(input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input logic we);
      @(negedge clk);
      bus.addr_i   = a;
      bus.wdata_i  = d;
      bus.funct3_i = f3;
      bus.we_i     = we;
      #1;
   endtask

   task automatic idle();
      op(32'h0, 32'h0, F_NONE, 1'b0);
   endtask

   task automatic expect_val(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %h but scoreboard is empty", tag, obs);
         return;
      end
      e = exp_q.pop_front();
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
   endtask

   initial begin
      reset          = 1'b1;
      bus.addr_i     = '0;
      bus.wdata_i    = '0;
      bus.funct3_i   = F_NONE;
      bus.we_i       = 1'b0;
      bus.tx_ready_i = 1'b0;

      // Reset state
      op(STATUS_ADDR, 0, F_W, 0);
      expect_val(32'h1);          check("rst_status", bus.rdata_o);
      expect_val(32'h0);          check("rst_txvalid", 32'(bus.tx_valid_o));
      expect_val(32'h0);          check("rst_txdata", 32'(bus.tx_data_o));
      expect_val(32'h0);          check("rst_misalign", 32'(bus.misalign_o));
      reset = 1'b0;

      // 1: word store then sign/zero-extended sub-word loads
      op(32'h10, 32'hDEAD_BEEF, F_W, 1);
      op(32'h13, 0, F_B, 0);  expect_val(32'hFFFF_FFDE); check("lb_13", bus.rdata_o);
      op(32'h13, 0, F_BU, 0); expect_val(32'h0000_00DE); check("lbu_13", bus.rdata_o);
      op(32'h12, 0, F_H, 0);  expect_val(32'hFFFF_DEAD); check("lh_12", bus.rdata_o);
      op(32'h10, 0, F_HU, 0); expect_val(32'h0000_BEEF); check("lhu_10", bus.rdata_o);
      op(32'h10, 0, F_NONE, 0); expect_val(32'h0);       check("bad_f3_load", bus.rdata_o);
      op(32'h10, 0, 3'b110, 1);
      op(32'h10, 0, F_W, 0);  expect_val(32'hDEAD_BEEF); check("bad_f3_store", bus.rdata_o);

      // 2: byte/half stores and same-cycle read-old behaviour
      op(32'h20, 32'h0, F_W, 1);
      op(32'h21, 32'h55, F_B, 1);
      op(32'h22, 32'hAAAA, F_H, 1); expect_val(32'h0);   check("sh_old_half", bus.rdata_o);
      op(32'h20, 0, F_W, 0);  expect_val(32'hAAAA_5500); check("lw_20_merged", bus.rdata_o);
      op(32'h20, 32'h1234_5678, F_W, 1);
      expect_val(32'hAAAA_5500); check("sw_same_cycle_old", bus.rdata_o);
      op(32'h20, 0, F_W, 0);  expect_val(32'h1234_5678); check("lw_20_new", bus.rdata_o);

      // 3: misalignment trapping and clearing
      op(32'h08, 32'h1122_3344, F_W, 1);
      op(32'h06, 0, F_W, 0);  expect_val(32'h0);         check("lw_06_zero", bus.rdata_o);
      idle();                 expect_val(32'h1);         check("mis_set_load", 32'(bus.misalign_o));
      op(STATUS_ADDR, 0, F_W, 0); expect_val(32'h9);     check("status_mis", bus.rdata_o);
      op(CLEAR_ADDR, 32'h1, F_W, 1);
      op(32'h07, 0, F_NONE, 0); expect_val(32'h0);       check("mis_cleared", 32'(bus.misalign_o));
      idle();                 expect_val(32'h0);         check("idle_no_mis", 32'(bus.misalign_o));
      op(32'h0B, 32'hFFFF, F_H, 1);
      op(32'h08, 0, F_W, 0);  expect_val(32'h1122_3344); check("sh_0b_suppressed", bus.rdata_o);
      expect_val(32'h1);      check("mis_set_store", 32'(bus.misalign_o));
      op(CLEAR_ADDR, 32'h1, F_W, 1);

      // 4: overflow on 9th push, then in-order drain
      for (int i = 0; i < 9; i++) op(TXDATA_ADDR, 32'hA0 + 32'(i), F_B, 1);
      op(STATUS_ADDR, 0, F_W, 0); expect_val(32'h0000_0806); check("status_full_ovf", bus.rdata_o);
      op(STATUS_ADDR + 32'h1, 0, F_BU, 0); expect_val(32'h08); check("status_count_byte", bus.rdata_o);
      for (int i = 0; i < 8; i++) begin
         idle();
         bus.tx_ready_i = 1'b1;
         #1;
         expect_val(32'hA0 + 32'(i)); check("drain4_data", 32'(bus.tx_data_o));
         expect_val(32'h1);           check("drain4_valid", 32'(bus.tx_valid_o));
      end
      idle();
      bus.tx_ready_i = 1'b0;
      expect_val(32'h0); check("drain4_empty", 32'(bus.tx_valid_o));

      // 5: push+pop on a full FIFO
      op(CLEAR_ADDR, 32'h2, F_W, 1);
      op(STATUS_ADDR, 0, F_W, 0); expect_val(32'h1); check("ovf_cleared", bus.rdata_o);
      for (int i = 0; i < 8; i++) op(TXDATA_ADDR, 32'h1234_56C0 + 32'(i), F_W, 1);
      op(TXDATA_ADDR, 32'h1234_56C8, F_W, 1);
      bus.tx_ready_i = 1'b1;
      #1;
      expect_val(32'hC0); check("full_pushpop_head", 32'(bus.tx_data_o));
      op(STATUS_ADDR, 0, F_W, 0);
      bus.tx_ready_i = 1'b0;
      expect_val(32'h0000_0802); check("status_pushpop", bus.rdata_o);
      for (int i = 1; i <= 8; i++) begin
         idle();
         bus.tx_ready_i = 1'b1;
         #1;
         expect_val(32'hC0 + 32'(i)); check("drain5_data", 32'(bus.tx_data_o));
      end
      idle();
      bus.tx_ready_i = 1'b0;
      expect_val(32'h0); check("drain5_empty", 32'(bus.tx_valid_o));

      // 6: asynchronous reset mid-burst
      op(32'h40, 32'hCAFE_F00D, F_W, 1);
      for (int i = 0; i < 3; i++) op(TXDATA_ADDR, 32'hE0 + 32'(i), F_B, 1);
      op(CYCLE_LO_ADDR, 0, F_W, 0);
      expect_val(32'h1); check("pre_reset_valid", 32'(bus.tx_valid_o));
      reset = 1'b1;
      #1;
      expect_val(32'h0); check("async_rst_valid", 32'(bus.tx_valid_o));
      expect_val(32'h0); check("async_rst_cycle_lo", bus.rdata_o);
      @(negedge clk);
      reset = 1'b0;
      op(32'h40, 0, F_W, 0); expect_val(32'hCAFE_F00D); check("ram_survives_reset", bus.rdata_o);
      op(STATUS_ADDR, 0, F_W, 0); expect_val(32'h1);     check("status_after_reset", bus.rdata_o);
      idle(); idle(); idle();
      op(CYCLE_LO_ADDR, 0, F_W, 0); expect_val(tb_cyc[31:0]);  check("cycle_lo", bus.rdata_o);
      op(CYCLE_HI_ADDR, 0, F_W, 0); expect_val(tb_cyc[63:32]); check("cycle_hi", bus.rdata_o);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
